// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants and coordinate type.
// Shared by the sync generator and its users.
package vga_timing_pkg;

  localparam int CLK_DIV   = 4;
  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_DISPLAY + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/clk_tick_div.sv
// Free-running divider producing a one-clock tick
// every DIV system clocks.
module clk_tick_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // Count 0..DIV-1 and wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel enable, x/y, syncs, video_on.
// frame_tick is generated only when VGA_FRAME_TICK_EN is defined.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = vga_timing_pkg::CLK_DIV,
  parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pixel_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_tick
);

  localparam int HT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int VT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t X_LAST = coord_t'(HT - 1);
  localparam coord_t Y_LAST = coord_t'(VT - 1);
  localparam coord_t X_DISP = coord_t'(H_DISPLAY);
  localparam coord_t Y_DISP = coord_t'(V_DISPLAY);
  localparam coord_t HS_S   = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HS_E   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam coord_t VS_S   = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t VS_E   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC);

  coord_t x_next;
  coord_t y_next;

  clk_tick_div #(
    .DIV (CLK_DIV)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .tick  (pixel_tick)
  );

  // Next coordinates: advance one pixel per tick, wrap line/frame.
  always_comb begin
    x_next = x;
    y_next = y;
    if (pixel_tick) begin
      if (x == X_LAST) begin
        x_next = '0;
        y_next = (y == Y_LAST) ? '0 : y + 10'd1;
      end else begin
        x_next = x + 10'd1;
      end
    end
  end

  // Coordinates and syncs register together so they never skew.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x        <= '0;
      y        <= '0;
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      video_on <= 1'b1;
    end else begin
      x        <= x_next;
      y        <= y_next;
      hsync    <= !((x_next >= HS_S) && (x_next < HS_E));
      vsync    <= !((y_next >= VS_S) && (y_next < VS_E));
      video_on <= (x_next < X_DISP) && (y_next < Y_DISP);
    end
  end

`ifdef VGA_FRAME_TICK_EN
  assign frame_tick = pixel_tick && (x == X_LAST) && (y == Y_LAST);
`else
  assign frame_tick = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: scaled and full-size instances
// checked every clock against an arithmetic timing model.
module tb_vga_sync_gen;

  localparam int D  = 4;
  localparam int HD = 16, HF = 2, HS = 4, HB = 3;
  localparam int VD = 10, VF = 2, VS = 2, VB = 3;
  localparam int FRAME = D * (HD + HF + HS + HB) * (VD + VF + VS + VB);

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       s_pt, s_hs, s_vs, s_vo, s_ft;
  logic [9:0] s_x, s_y;
  logic       d_pt, d_hs, d_vs, d_vo, d_ft;
  logic [9:0] d_x, d_y;

  int checks = 0;
  int errors = 0;
  int n;
  bit phase1 = 0;
  int last_ft = -1;
  int ft_cnt = 0;
  int hs_low = 0;
  int s_hs_low = 0;

  always #5 clk = ~clk;

  // Clock edges seen since the last reset release.
  always @(posedge clk or posedge reset)
    if (reset) n <= 0;
    else n <= n + 1;

  vga_sync_gen #(
    .CLK_DIV(D), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS),
    .H_BACK(HB), .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS),
    .V_BACK(VB)
  ) u_s (
    .clk(clk), .reset(reset), .pixel_tick(s_pt), .x(s_x), .y(s_y),
    .hsync(s_hs), .vsync(s_vs), .video_on(s_vo), .frame_tick(s_ft)
  );

  vga_sync_gen u_d (
    .clk(clk), .reset(reset), .pixel_tick(d_pt), .x(d_x), .y(d_y),
    .hsync(d_hs), .vsync(d_vs), .video_on(d_vo), .frame_tick(d_ft)
  );

  // Expected outputs after nn clock edges, from the timing rules.
  function automatic void model(
    input int nn, input int dv,
    input int hd, input int hf, input int hs, input int hb,
    input int vd, input int vf, input int vs, input int vb,
    output logic [9:0] ex, output logic [9:0] ey,
    output logic et, output logic ehs, output logic evs,
    output logic evo, output logic eft);
    int ht, vt, p, xi, yi;
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    p = nn / dv;
    xi = p % ht;
    yi = (p / ht) % vt;
    ex = 10'(xi);
    ey = 10'(yi);
    et = ((nn % dv) == dv - 1);
    ehs = !(xi >= hd + hf && xi < hd + hf + hs);
    evs = !(yi >= vd + vf && yi < vd + vf + vs);
    evo = (xi < hd) && (yi < vd);
`ifdef VGA_FRAME_TICK_EN
    eft = et && (xi == ht - 1) && (yi == vt - 1);
`else
    eft = 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_now;
    logic [9:0] ex, ey;
    logic et, ehs, evs, evo, eft;
    model(n, D, HD, HF, HS, HB, VD, VF, VS, VB,
          ex, ey, et, ehs, evs, evo, eft);
    chk("s_x", 32'(s_x), 32'(ex));
    chk("s_y", 32'(s_y), 32'(ey));
    chk("s_tick", 32'(s_pt), 32'(et));
    chk("s_hsync", 32'(s_hs), 32'(ehs));
    chk("s_vsync", 32'(s_vs), 32'(evs));
    chk("s_video_on", 32'(s_vo), 32'(evo));
    chk("s_frame_tick", 32'(s_ft), 32'(eft));
    model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33,
          ex, ey, et, ehs, evs, evo, eft);
    chk("d_x", 32'(d_x), 32'(ex));
    chk("d_y", 32'(d_y), 32'(ey));
    chk("d_tick", 32'(d_pt), 32'(et));
    chk("d_hsync", 32'(d_hs), 32'(ehs));
    chk("d_vsync", 32'(d_vs), 32'(evs));
    chk("d_video_on", 32'(d_vo), 32'(evo));
    chk("d_frame_tick", 32'(d_ft), 32'(eft));
  endtask

  task automatic step;
    @(negedge clk);
    compare_now();
    if (phase1) begin
      if (s_ft) begin
        if (last_ft >= 0) chk("ft_period", 32'(n - last_ft), 32'(FRAME));
        last_ft = n;
        ft_cnt++;
      end
      if (n < 3200 && !d_hs) hs_low++;
      if (n < D * 25 && !s_hs) s_hs_low++;
    end
  endtask

  task automatic reset_values(input string tag);
    chk({tag, "_x"}, 32'(s_x), 0);
    chk({tag, "_y"}, 32'(s_y), 0);
    chk({tag, "_hs"}, 32'(s_hs), 1);
    chk({tag, "_vs"}, 32'(s_vs), 1);
    chk({tag, "_vo"}, 32'(s_vo), 1);
    chk({tag, "_pt"}, 32'(s_pt), 0);
    chk({tag, "_ft"}, 32'(s_ft), 0);
    chk({tag, "_dx"}, 32'(d_x), 0);
    chk({tag, "_dhs"}, 32'(d_hs), 1);
  endtask

  initial begin
    int offs [8] = '{1, 2, 3, 4, 6, 7, 8, 9};
    bit found;

    // Power-on reset.
    step();
    step();
    reset_values("por");
    reset = 1'b0;

    // Two full scaled frames plus the first full-size line.
    phase1 = 1;
    for (int i = 0; i < 3500; i++) step();
    phase1 = 0;
`ifdef VGA_FRAME_TICK_EN
    chk("ft_count", 32'(ft_cnt), 2);
`else
    chk("ft_count", 32'(ft_cnt), 0);
`endif
    chk("d_hs_low_clks", 32'(hs_low), 384);
    chk("s_hs_low_clks", 32'(s_hs_low), 32'(HS * D));

    // Directed reset in the middle of a scaled frame.
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      step();
      if (s_x == 10'd12 && s_y == 10'd5) found = 1;
    end
    chk("wait_mid_frame", 32'(found), 1);
    #2 reset = 1'b1;
    #1 reset_values("mid");
    @(negedge clk);
    compare_now();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) step();

    // Random run lengths and asynchronous reset points.
    for (int r = 0; r < 6; r++) begin
      int len;
      len = $urandom_range(1200, 50);
      for (int i = 0; i < len; i++) step();
      #(offs[$urandom_range(7, 0)]) reset = 1'b1;
      #1 reset_values("rnd");
      for (int i = 0; i < $urandom_range(3, 1); i++) step();
      reset = 1'b0;
    end
    for (int i = 0; i < 200; i++) step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
